// File: rtl/branch_pkg.sv
// branch_pkg: shared definitions for the branch resolver, the direction
// predictor and the fetch logic.
//   PC_W        default program-counter width
//   br_entry_t  one in-flight prediction {take, alt_pc}
//   sat_inc16   saturating 16-bit increment used by the statistics counters
package branch_pkg;

  localparam int PC_W = 32;

  typedef struct packed {
    logic            take;
    logic [PC_W-1:0] alt_pc;
  } br_entry_t;

  // Counts stick at all-ones instead of wrapping back to zero
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'h0001;
    end
    return result;
  endfunction

endpackage

// File: rtl/bp_queue.sv
// bp_queue: in-order FIFO of in-flight branch predictions.
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   push, push_take,     write one entry {take, alt} at the tail
//   push_alt
//   pop                  retire the head entry
//   clear                drop every entry (wins over push/pop)
//   head_take, head_alt  oldest entry, valid while count != 0
//   count                occupancy, 0..DEPTH
// The caller guarantees push only when not full (or when popping in the
// same cycle) and pop only when not empty.
module bp_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            push_take,
  input  logic [PC_W-1:0] push_alt,
  input  logic            pop,
  input  logic            clear,
  output logic            head_take,
  output logic [PC_W-1:0] head_alt,
  output logic [CW-1:0]   count
);

  logic            take_mem_r [DEPTH];
  logic [PC_W-1:0] alt_mem_r  [DEPTH];
  logic [AW-1:0]   wptr_r;
  logic [AW-1:0]   rptr_r;
  logic [CW-1:0]   count_r;

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push) begin
        wptr_r <= wptr_r + AW'(1);
      end else begin
        wptr_r <= wptr_r;
      end
      if (pop) begin
        rptr_r <= rptr_r + AW'(1);
      end else begin
        rptr_r <= rptr_r;
      end
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (rst && push && !clear) begin
      take_mem_r[wptr_r] <= push_take;
      alt_mem_r[wptr_r]  <= push_alt;
    end
  end

  assign head_take = take_mem_r[rptr_r];
  assign head_alt  = alt_mem_r[rptr_r];
  assign count     = count_r;

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: tracks in-flight branch predictions and resolves them in
// order against the execute-stage outcome.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   pred_valid/take/alt_pc       new prediction from fetch
//   stall                        freezes push, pop and output pulses
//   res_valid, res_taken         resolution of the oldest branch
//   upd_branch, upd_taken        one-cycle predictor update strobe
//   flush, redirect_pc           one-cycle squash and fetch redirect
//   full                         queue holds DEPTH entries
//   res_err                      sticky: resolution seen with empty queue
//   br_count, mis_count          statistics (only with BRANCH_STATS_EN)
// Optional feature macro: BRANCH_STATS_EN enables the saturating counters.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = branch_pkg::PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  input  logic            pred_take,
  input  logic [PC_W-1:0] pred_alt_pc,
  input  logic            stall,
  input  logic            res_valid,
  input  logic            res_taken,
  output logic            upd_branch,
  output logic            upd_taken,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic            full,
  output logic            res_err,
  output logic [15:0]     br_count,
  output logic [15:0]     mis_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [CW-1:0]   count_s;
  logic            head_take_s;
  logic [PC_W-1:0] head_alt_s;
  logic            full_s;
  logic            empty_s;
  logic            flush_vis_s;
  logic            pop_s;
  logic            mis_s;
  logic            push_s;

  // Pending pulses are captured at pop time and shown on the first unstalled
  // cycle afterwards, so a stall delays an event instead of losing it.
  logic            pend_upd_r;
  logic            pend_taken_r;
  logic            pend_flush_r;
  logic [PC_W-1:0] redirect_r;
  logic            res_err_r;

  bp_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_take (pred_take),
    .push_alt  (pred_alt_pc),
    .pop       (pop_s),
    .clear     (mis_s),
    .head_take (head_take_s),
    .head_alt  (head_alt_s),
    .count     (count_s)
  );

  // Push/pop qualification; a mispredict pop discards any same-cycle push
  always_comb begin
    full_s      = (count_s == CW'(DEPTH));
    empty_s     = (count_s == {CW{1'b0}});
    flush_vis_s = pend_flush_r & ~stall;
    pop_s       = res_valid & ~stall & ~empty_s;
    mis_s       = pop_s & (res_taken != head_take_s);
    push_s      = pred_valid & ~stall & ~flush_vis_s & (~full_s | pop_s) & ~mis_s;
  end

  // Event capture at pop; pending events retire on the first unstalled cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_upd_r   <= 1'b0;
      pend_taken_r <= 1'b0;
      pend_flush_r <= 1'b0;
    end else if (pop_s) begin
      pend_upd_r   <= 1'b1;
      pend_taken_r <= res_taken;
      pend_flush_r <= mis_s;
    end else if (!stall) begin
      pend_upd_r   <= 1'b0;
      pend_taken_r <= 1'b0;
      pend_flush_r <= 1'b0;
    end else begin
      pend_upd_r   <= pend_upd_r;
      pend_taken_r <= pend_taken_r;
      pend_flush_r <= pend_flush_r;
    end
  end

  // Redirect target latched from the mispredicted head entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      redirect_r <= {PC_W{1'b0}};
    end else if (mis_s) begin
      redirect_r <= head_alt_s;
    end else begin
      redirect_r <= redirect_r;
    end
  end

  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_err_r <= 1'b0;
    end else if (res_valid && !stall && empty_s) begin
      res_err_r <= 1'b1;
    end else begin
      res_err_r <= res_err_r;
    end
  end

  assign upd_branch  = pend_upd_r & ~stall;
  assign upd_taken   = pend_taken_r & pend_upd_r & ~stall;
  assign flush       = flush_vis_s;
  assign redirect_pc = redirect_r;
  assign full        = full_s;
  assign res_err     = res_err_r;

`ifdef BRANCH_STATS_EN
  logic [15:0] br_cnt_r;
  logic [15:0] mis_cnt_r;

  // Saturating resolved-branch and misprediction counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      br_cnt_r  <= 16'h0000;
      mis_cnt_r <= 16'h0000;
    end else begin
      if (pop_s) begin
        br_cnt_r <= sat_inc16(br_cnt_r);
      end else begin
        br_cnt_r <= br_cnt_r;
      end
      if (mis_s) begin
        mis_cnt_r <= sat_inc16(mis_cnt_r);
      end else begin
        mis_cnt_r <= mis_cnt_r;
      end
    end
  end

  assign br_count  = br_cnt_r;
  assign mis_count = mis_cnt_r;
`else
  assign br_count  = 16'h0000;
  assign mis_count = 16'h0000;
`endif

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of in-flight predictions (power of two, 2..8).
REQ-002 SHALL have parameter PC_W, default 32, the PC width in bits.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port pred_valid  in  1  the fetch stage issued a branch prediction this cycle.
REQ-006 SHALL have port pred_take  in  1  the predicted direction from the 2-bit predictor (1 = taken).
REQ-007 SHALL have port pred_alt_pc  in  PC_W  the recovery PC if the prediction is wrong.
REQ-008 SHALL have port stall  in  1  pipeline stall; freezes push and pop.
REQ-009 SHALL have port res_valid  in  1  the execute stage resolved the oldest in-flight branch.
REQ-010 SHALL have port res_taken  in  1  the actual branch outcome.
REQ-011 SHALL have port upd_branch  out  1  update strobe to the predictor's Branch input.
REQ-012 SHALL have port upd_taken  out  1  actual outcome to the predictor's taken input.
REQ-013 SHALL have port flush  out  1  squash the younger pipeline stages.
REQ-014 SHALL have port redirect_pc  out  PC_W  the fetch redirect target, valid while flush=1.
REQ-015 SHALL have port full  out  1  the queue holds DEPTH entries.
REQ-016 SHALL have port res_err  out  1  sticky flag: a resolution arrived with the queue empty.
REQ-017 SHALL have port br_count  out  16  count of resolved branches.
REQ-018 SHALL have port mis_count  out  16  count of mispredictions.

Function
REQ-019 SHALL keep an in-order queue of {take, alt_pc} entries with wrap-around read/write pointers and an occupancy count of 0..DEPTH.
REQ-020 SHALL push when pred_valid=1, stall=0, full=0 and the current cycle is not a flush cycle.
REQ-021 SHALL drop a prediction that arrives while full=1 (no state change), unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-022 SHALL pop the head entry when res_valid=1, stall=0 and the queue is not empty.
REQ-023 SHALL ignore res_valid when the queue is empty and set res_err to 1 until reset.
REQ-024 SHALL pulse upd_branch=1 for exactly one cycle, one cycle after each pop, with upd_taken=res_taken.
REQ-025 SHALL detect a misprediction when res_taken != head.take at pop time.
REQ-026 SHALL, on a misprediction, assert flush=1 for exactly one cycle, one cycle after the pop, with redirect_pc=head.alt_pc.
REQ-027 SHALL clear the entire queue (count=0, pointers equal) on a misprediction, because all younger entries are wrong-path.
REQ-028 SHALL discard any push presented in the same cycle as the misprediction pop.
REQ-029 SHALL, while flush=1, accept no push (the fetched instruction is wrong-path).
REQ-030 SHALL compute full combinationally from the occupancy count (count==DEPTH).
REQ-031 SHALL hold upd_branch, upd_taken and flush at 0 while stall=1; no event may be lost or duplicated across a stall.

Reset
REQ-032 SHALL, while rst=0 at a clock edge, set count=0, pointers=0, upd_branch=0, upd_taken=0, flush=0, redirect_pc=0, res_err=0, br_count=0 and mis_count=0.
REQ-033 SHALL abandon any in-flight pulse when reset is applied mid-operation; no output pulse may be emitted in the first cycle after reset is released.

Configuration
REQ-034 SHALL, with macro BRANCH_STATS_EN defined, increment br_count on every pop and mis_count on every misprediction, with both counters saturating at 16'hFFFF.
REQ-035 SHALL, without BRANCH_STATS_EN, keep br_count and mis_count as ports tied to 0 with no counter logic.

Structure
REQ-036 SHALL place PC_W and the queue-entry typedef {take, alt_pc} in shared package branch_pkg, for reuse by the predictor and fetch logic.
REQ-037 SHALL implement the queue as sub-module bp_queue (push, pop, clear, head, count); the compare, flush and update logic stays in branch_resolver.

Verification
REQ-038 SHALL verify: push take=1 alt=0x100, then resolve taken=1 -> upd_branch pulse with upd_taken=1, flush=0, queue empty.
REQ-039 SHALL verify: push take=1 alt=0x200 and take=0 alt=0x300, then resolve taken=0 -> flush=1 for one cycle, redirect_pc=0x200, count=0, mis_count=1.
REQ-040 SHALL verify: 4 pushes (full=1), a 5th push dropped, then push and resolve in the same cycle -> count stays 4 and entry order is preserved.
REQ-041 SHALL verify: res_valid with the queue empty -> res_err=1 and no upd_branch pulse; res_err stays 1 until rst=0.
REQ-042 SHALL verify: stall=1 with res_valid and pred_valid held -> no change; stall released -> exactly one pop and one push.
REQ-043 SHALL verify: rst=0 on the cycle after a misprediction pop -> flush=0 and all counters 0 next cycle.
